// File: rtl/router_nport.sv
// rtl/router_nport.sv - packet router: header decode, parity/length check, per-channel FIFOs with idle flush
module router_nport #(
    parameter int DW      = 8,
    parameter int NPORT   = 3,
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 30
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DW-1:0]       din,
    input  logic                pkt_valid,
    input  logic [NPORT-1:0]    rd_en,
    output logic [NPORT-1:0]    vld_out,
    output logic [NPORT*DW-1:0] dout,
    output logic                busy,
    output logic                err,
    output logic                drop
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int LW = DW - 2;
    localparam logic [2:0]  NP    = 3'(NPORT);
    localparam logic [AW:0] P_ONE = 1;
    localparam logic [TW-1:0] T_ONE = 1;

    typedef enum logic [1:0] {IDLE, LOAD, CHECK, DROP} state_t;
    state_t state, state_nxt;

    logic [1:0]       hdr_addr, cur_addr;
    logic [LW-1:0]    hdr_len, len_r, count_r;
    logic [DW-1:0]    par_r, rx_par_r;
    logic [NPORT-1:0] empty_v, full_v, flush_v, wr_v;
    logic [3:0]       empty_pad, full_pad, flush_pad;
    logic             addr_ok, hdr_take, drop_take, ld_take;

    assign hdr_addr = din[1:0];
    assign hdr_len  = din[DW-1:2];
    assign addr_ok  = {1'b0, hdr_addr} < NP;

    // Widen channel status to the full 2-bit address space so any header indexes safely.
    always_comb begin
        empty_pad = '1;
        full_pad  = '0;
        flush_pad = '0;
        for (int k = 0; k < NPORT; k++) begin
            empty_pad[k] = empty_v[k];
            full_pad[k]  = full_v[k];
            flush_pad[k] = flush_v[k];
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        hdr_take  = 1'b0;
        drop_take = 1'b0;
        ld_take   = 1'b0;
        case (state)
            IDLE: begin
                if (pkt_valid) begin
                    if (!addr_ok) begin
                        drop_take = 1'b1;
                        state_nxt = DROP;
                    end else if (!empty_pad[hdr_addr]) begin
                        busy = 1'b1;
                    end else begin
                        hdr_take  = 1'b1;
                        state_nxt = LOAD;
                    end
                end
            end
            LOAD: begin
                busy    = full_pad[cur_addr];
                ld_take = !full_pad[cur_addr];
                // A flush of the target abandons the packet; a parity byte taken now ends it.
                if (flush_pad[cur_addr])
                    state_nxt = (ld_take && !pkt_valid) ? IDLE : DROP;
                else if (ld_take && !pkt_valid)
                    state_nxt = CHECK;
            end
            CHECK: begin
                busy      = 1'b1;
                state_nxt = IDLE;
            end
            DROP: begin
                if (!pkt_valid)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cur_addr <= '0;
            len_r    <= '0;
            count_r  <= '0;
            par_r    <= '0;
            rx_par_r <= '0;
            err      <= 1'b0;
            drop     <= 1'b0;
        end else begin
            state <= state_nxt;
            drop  <= drop_take;
            if (hdr_take) begin
                cur_addr <= hdr_addr;
                len_r    <= hdr_len;
                par_r    <= din;
                count_r  <= '0;
            end
            if (ld_take && !flush_pad[cur_addr]) begin
                if (pkt_valid) begin
                    par_r   <= par_r ^ din;
                    count_r <= count_r + LW'(1);
                end else begin
                    rx_par_r <= din;
                end
            end
            if (state == CHECK)
                err <= (rx_par_r != par_r) || (count_r != len_r);
        end
    end

    for (genvar k = 0; k < NPORT; k++) begin : g_ch
        logic [DW-1:0]   mem [DEPTH];
        logic [AW:0]     wptr, rptr;
        logic [TW-1:0]   timer;
        logic [DW-1:0]   dout_r;
        logic            rd_ok;

        assign empty_v[k] = (wptr == rptr);
        assign full_v[k]  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
        assign flush_v[k] = (timer == TW'(TIMEOUT));
        assign wr_v[k]    = ((hdr_take && hdr_addr == 2'(k)) ||
                             (ld_take && cur_addr == 2'(k))) && !flush_v[k];
        assign rd_ok      = rd_en[k] && !empty_v[k] && !flush_v[k];
        assign vld_out[k] = !empty_v[k];
        assign dout[k*DW +: DW] = dout_r;

        always_ff @(posedge clk) begin
            if (rst) begin
                wptr   <= '0;
                rptr   <= '0;
                timer  <= '0;
                dout_r <= '0;
            end else if (flush_v[k]) begin
                wptr  <= '0;
                rptr  <= '0;
                timer <= '0;
            end else begin
                if (wr_v[k])
                    wptr <= wptr + P_ONE;
                if (rd_ok) begin
                    rptr   <= rptr + P_ONE;
                    dout_r <= mem[rptr[AW-1:0]];
                end
                if (!empty_v[k] && !rd_en[k])
                    timer <= timer + T_ONE;
                else
                    timer <= '0;
            end
        end

        always_ff @(posedge clk) begin
            if (wr_v[k])
                mem[wptr[AW-1:0]] <= din;
        end
    end
endmodule

// File: tb/tb_router_nport.sv
// tb/tb_router_nport.sv - directed self-checking bench for router_nport
module tb_router_nport;
    logic        clk;
    logic        rst;
    logic [7:0]  din;
    logic        pkt_valid;
    logic [2:0]  rd_en;
    logic [2:0]  vld_out;
    logic [23:0] dout;
    logic        busy;
    logic        err;
    logic        drop;

    int checks   = 0;
    int failures = 0;

    router_nport #(.DW(8), .NPORT(3), .DEPTH(16), .TIMEOUT(30)) dut (
        .clk(clk), .rst(rst), .din(din), .pkt_valid(pkt_valid), .rd_en(rd_en),
        .vld_out(vld_out), .dout(dout), .busy(busy), .err(err), .drop(drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    task automatic send_byte(input logic [7:0] b, input logic v);
        int n;
        @(negedge clk);
        din = b;
        pkt_valid = v;
        #1;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 100) begin
            checks++; failures++;
            $display("FAIL send_wait busy=%b required=0", busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; din = '0; pkt_valid = 1'b0; rd_en = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (vld_out !== 3'b000) begin failures++; $display("FAIL rst_vld got=%b exp=000", vld_out); end
        checks++; if (dout !== 24'h0) begin failures++; $display("FAIL rst_dout got=%h exp=0", dout); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL rst_err got=%b exp=0", err); end
        checks++; if (drop !== 1'b0) begin failures++; $display("FAIL rst_drop got=%b exp=0", drop); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
    endtask

    task automatic test_basic();
        logic [7:0] pkt[$];
        logic [7:0] p;
        p = {6'd8, 2'd0};
        pkt.push_back(p);
        for (int i = 0; i < 8; i++) begin
            pkt.push_back(8'h10 + 8'(i));
            p ^= 8'h10 + 8'(i);
        end
        pkt.push_back(p);
        for (int i = 0; i < 10; i++) send_byte(pkt[i], i < 9);
        repeat (2) @(negedge clk);
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL basic_err got=%b exp=0", err); end
        checks++; if (vld_out !== 3'b001) begin failures++; $display("FAIL basic_vld got=%b exp=001", vld_out); end
        for (int i = 0; i <= 10; i++) begin
            @(negedge clk);
            if (i > 0) begin
                checks++;
                if (dout[7:0] !== pkt[i-1]) begin failures++; $display("FAIL basic_data[%0d] got=%h exp=%h", i-1, dout[7:0], pkt[i-1]); end
            end
            rd_en[0] = (i < 10);
        end
        checks++; if (vld_out[0] !== 1'b0) begin failures++; $display("FAIL basic_vld_fall got=%b exp=0", vld_out[0]); end
    endtask

    task automatic test_stream();
        logic [7:0] pkt[$];
        logic [7:0] p;
        int sent, got, stuck;
        logic pend;
        p = {6'd20, 2'd1};
        pkt.push_back(p);
        for (int i = 0; i < 20; i++) begin
            pkt.push_back(8'h30 + 8'(i));
            p ^= 8'h30 + 8'(i);
        end
        pkt.push_back(p);
        sent = 0; got = 0; stuck = 0; pend = 1'b0;
        for (int cyc = 0; cyc < 300 && got < 22; cyc++) begin
            @(negedge clk);
            if (pend) begin
                checks++;
                if (dout[15:8] !== pkt[got]) begin failures++; $display("FAIL stream_data[%0d] got=%h exp=%h", got, dout[15:8], pkt[got]); end
                got++;
            end
            if (sent < 22) begin din = pkt[sent]; pkt_valid = (sent < 21); end
            else pkt_valid = 1'b0;
            rd_en[1] = (sent >= 7) && vld_out[1];
            pend = rd_en[1];
            #1;
            if (sent < 22) begin
                if (busy) stuck++;
                else sent++;
            end
        end
        rd_en = '0;
        checks++; if (got != 22) begin failures++; $display("FAIL stream_count got=%0d exp=22", got); end
        checks++; if (stuck != 0) begin failures++; $display("FAIL stream_busy got=%0d exp=0", stuck); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL stream_err got=%b exp=0", err); end
    endtask

    task automatic test_timeout();
        logic [7:0] pkt[$];
        logic [7:0] p;
        int sent, bc;
        p = {6'd16, 2'd2};
        pkt.push_back(p);
        for (int i = 0; i < 16; i++) begin
            pkt.push_back(8'h50 + 8'(i));
            p ^= 8'h50 + 8'(i);
        end
        pkt.push_back(p);
        sent = 0;
        for (int cyc = 0; cyc < 40 && sent < 16; cyc++) begin
            @(negedge clk);
            din = pkt[sent]; pkt_valid = 1'b1;
            #1;
            if (!busy) sent++;
        end
        @(negedge clk);
        din = pkt[16]; pkt_valid = 1'b1;
        #1;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL tmo_busy_full got=%b exp=1", busy); end
        bc = 1;
        while (busy === 1'b1 && bc < 60) begin
            @(negedge clk);
            #1;
            if (busy) bc++;
        end
        checks++; if (bc != 16) begin failures++; $display("FAIL tmo_busy_cycles got=%0d exp=16", bc); end
        checks++; if (vld_out[2] !== 1'b0) begin failures++; $display("FAIL tmo_flushed got=%b exp=0", vld_out[2]); end
        send_byte(pkt[17], 1'b0);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL tmo_drop_busy got=%b exp=0", busy); end
        repeat (2) @(negedge clk);
        checks++; if (vld_out !== 3'b000) begin failures++; $display("FAIL tmo_vld_after got=%b exp=000", vld_out); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL tmo_err got=%b exp=0", err); end
    endtask

    task automatic test_parity_err();
        logic [7:0] pkt[$];
        logic [7:0] good[$];
        logic [7:0] p;
        pkt.push_back({6'd14, 2'd2});
        for (int i = 0; i < 14; i++) pkt.push_back(8'hA0 + 8'(i));
        pkt.push_back(8'h25);
        for (int i = 0; i < 16; i++) send_byte(pkt[i], i < 15);
        repeat (2) @(negedge clk);
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL perr_err got=%b exp=1", err); end
        checks++; if (vld_out !== 3'b100) begin failures++; $display("FAIL perr_vld got=%b exp=100", vld_out); end
        for (int i = 0; i <= 16; i++) begin
            @(negedge clk);
            if (i > 0) begin
                checks++;
                if (dout[23:16] !== pkt[i-1]) begin failures++; $display("FAIL perr_data[%0d] got=%h exp=%h", i-1, dout[23:16], pkt[i-1]); end
            end
            rd_en[2] = (i < 16);
        end
        checks++; if (vld_out[2] !== 1'b0) begin failures++; $display("FAIL perr_vld_fall got=%b exp=0", vld_out[2]); end
        p = {6'd2, 2'd0};
        good.push_back(p);
        good.push_back(8'h11); p ^= 8'h11;
        good.push_back(8'h22); p ^= 8'h22;
        good.push_back(p);
        for (int i = 0; i < 4; i++) send_byte(good[i], i < 3);
        repeat (2) @(negedge clk);
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL perr_clear got=%b exp=0", err); end
        for (int i = 0; i <= 4; i++) begin
            @(negedge clk);
            if (i > 0) begin
                checks++;
                if (dout[7:0] !== good[i-1]) begin failures++; $display("FAIL perr_good[%0d] got=%h exp=%h", i-1, dout[7:0], good[i-1]); end
            end
            rd_en[0] = (i < 4);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] pkt[$];
        logic [7:0] p;
        send_byte({6'd0, 2'd1}, 1'b1);
        send_byte(8'hFF, 1'b0);
        repeat (2) @(negedge clk);
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL rmid_pre_err got=%b exp=1", err); end
        send_byte({6'd8, 2'd0}, 1'b1);
        for (int i = 0; i < 4; i++) send_byte(8'h61 + 8'(i), 1'b1);
        @(negedge clk);
        rst = 1'b1; din = 8'h65; pkt_valid = 1'b1;
        @(negedge clk);
        rst = 1'b0; din = 8'h77; pkt_valid = 1'b0;
        #1;
        checks++; if (vld_out !== 3'b000) begin failures++; $display("FAIL rmid_vld got=%b exp=000", vld_out); end
        checks++; if (dout !== 24'h0) begin failures++; $display("FAIL rmid_dout got=%h exp=0", dout); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL rmid_err got=%b exp=0", err); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rmid_busy got=%b exp=0", busy); end
        @(negedge clk);
        checks++; if (vld_out !== 3'b000) begin failures++; $display("FAIL rmid_no_parity got=%b exp=000", vld_out); end
        p = {6'd3, 2'd0};
        pkt.push_back(p);
        for (int i = 0; i < 3; i++) begin
            pkt.push_back(8'hC1 + 8'(i));
            p ^= 8'hC1 + 8'(i);
        end
        pkt.push_back(p);
        for (int i = 0; i < 5; i++) send_byte(pkt[i], i < 4);
        repeat (2) @(negedge clk);
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL rmid_post_err got=%b exp=0", err); end
        for (int i = 0; i <= 5; i++) begin
            @(negedge clk);
            if (i > 0) begin
                checks++;
                if (dout[7:0] !== pkt[i-1]) begin failures++; $display("FAIL rmid_data[%0d] got=%h exp=%h", i-1, dout[7:0], pkt[i-1]); end
            end
            rd_en[0] = (i < 5);
        end
    endtask

    task automatic test_drop();
        logic any_vld;
        any_vld = 1'b0;
        send_byte({6'd5, 2'd3}, 1'b1);
        send_byte(8'h01, 1'b1);
        checks++; if (drop !== 1'b1) begin failures++; $display("FAIL drop_pulse got=%b exp=1", drop); end
        any_vld |= (vld_out != 3'b000);
        send_byte(8'h02, 1'b1);
        checks++; if (drop !== 1'b0) begin failures++; $display("FAIL drop_width got=%b exp=0", drop); end
        for (int i = 3; i <= 5; i++) begin
            send_byte(8'(i), 1'b1);
            any_vld |= (vld_out != 3'b000);
        end
        send_byte(8'h00, 1'b0);
        any_vld |= (vld_out != 3'b000);
        @(negedge clk);
        din = {6'd1, 2'd1}; pkt_valid = 1'b1;
        #1;
        any_vld |= (vld_out != 3'b000);
        checks++; if (any_vld !== 1'b0) begin failures++; $display("FAIL drop_vld got=%b exp=0", any_vld); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL drop_next_busy got=%b exp=0", busy); end
        send_byte(8'h99, 1'b1);
        checks++; if (vld_out !== 3'b010) begin failures++; $display("FAIL drop_next_vld got=%b exp=010", vld_out); end
        send_byte(8'h05 ^ 8'h99, 1'b0);
        repeat (2) @(negedge clk);
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL drop_next_err got=%b exp=0", err); end
    endtask

    initial begin
        rst = 1'b1; din = '0; pkt_valid = 1'b0; rd_en = '0;
        test_reset();
        test_basic();
        test_stream();
        test_timeout();
        test_parity_err();
        test_reset_mid();
        test_drop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/router_nport.md
ROUTER_NPORT -- requirements
Module: router_nport

Interface
REQ-001 SHALL have parameter DW, default 8, meaning data byte width (header/payload/parity).
REQ-002 SHALL have parameter NPORT, default 3, meaning output channel count (legal 2..4).
REQ-003 SHALL have parameter DEPTH, default 16, meaning per-channel FIFO entries (power of 2, >=4).
REQ-004 SHALL have parameter TIMEOUT, default 30, meaning idle-read cycles before channel soft flush.
REQ-005 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-007 SHALL have port din  input  DW  packet byte: header, payload, then parity.
REQ-008 SHALL have port pkt_valid  input  1  high with header and payload bytes, low with parity byte.
REQ-009 SHALL have port rd_en  input  NPORT  per-channel read enable.
REQ-010 SHALL have port vld_out  output  NPORT  per-channel FIFO non-empty.
REQ-011 SHALL have port dout  output  NPORT*DW  channel k at bits [k*DW +: DW].
REQ-012 SHALL have port busy  output  1  din not consumed this cycle; sender holds din.
REQ-013 SHALL have port err  output  1  last packet had parity or length mismatch.
REQ-014 SHALL have port drop  output  1  one-cycle pulse: header with addr >= NPORT accepted and discarded.

Function
REQ-015 SHALL decode header as addr = din[1:0], len = din[DW-1:2].
REQ-016 SHALL run FSM states IDLE, LOAD, CHECK, DROP; a byte is consumed in a cycle where din is sampled and busy=0.
REQ-017 SHALL in IDLE, with pkt_valid=1 and addr<NPORT: busy=1 while FIFO[addr] non-empty; else consume header, write it to FIFO[addr], parity=header, count=0, go LOAD.
REQ-018 SHALL in IDLE, with pkt_valid=1 and addr>=NPORT: consume header, pulse drop, go DROP; nothing written.
REQ-019 SHALL in LOAD: busy=1 while FIFO[addr] full (write blocked even if same-cycle read frees an entry); else write din, and if pkt_valid=1 XOR into parity and count+1, if pkt_valid=0 treat din as parity byte, go CHECK.
REQ-020 SHALL in CHECK (one cycle, busy=1): set err=1 if received parity != accumulated parity or count != len, else err=0; go IDLE.
REQ-021 SHALL hold err until next CHECK or reset.
REQ-022 SHALL in DROP: busy=0, consume without writing; on byte with pkt_valid=0 go IDLE.
REQ-023 SHALL count payload modulo 2^(DW-2); len=0 packets legal (header then parity).
REQ-024 SHALL assert vld_out[k] combinationally = FIFO[k] non-empty.
REQ-025 SHALL on rd_en[k]=1 and FIFO[k] non-empty load dout[k] with oldest byte at the clock edge (1-cycle latency); rd_en on empty ignored, dout[k] holds.
REQ-026 SHALL permit simultaneous write and read on one FIFO when not full; occupancy unchanged.
REQ-027 SHALL keep per-channel timer: increments while vld_out[k]=1 and rd_en[k]=0, clears otherwise; at TIMEOUT, FIFO[k] flushed next edge (pointers cleared, dout[k] holds).
REQ-028 SHALL, if flushed channel is current LOAD target, go DROP; remaining bytes discarded, err unchanged.
REQ-029 SHALL wrap FIFO pointers modulo DEPTH; full/empty distinguished by extra pointer bit.
REQ-030 SHALL with pkt_valid=0 in IDLE keep busy=0 and consume nothing.

Reset
REQ-031 SHALL on rst=1 at an edge: FSM IDLE, all FIFOs empty, timers 0, parity/count 0, dout all 0, vld_out 0, err 0, drop 0; busy 0 next cycle.
REQ-032 SHALL abandon a packet in progress on reset mid-operation; post-reset bytes with pkt_valid=0 not treated as parity.

Verification
REQ-033 SHALL pass: 8-byte packet, addr 0, correct parity, then rd_en[0]=1 -> dout[0] yields header, 8 bytes, parity in order; err=0; vld_out[0] falls after 10th read.
REQ-034 SHALL pass: 20-byte packet, addr 1, rd_en[1] raised after 6th payload byte, DEPTH=16 -> busy never stuck, 22 bytes read in order, err=0.
REQ-035 SHALL pass: 16-byte packet, addr 2, no reads -> busy=1 after 16 writes, held until TIMEOUT=30 idle cycles flush FIFO[2], FSM to DROP, remaining bytes consumed, busy=0.
REQ-036 SHALL pass: 14-byte packet, addr 2, parity forced 8'h25 (mismatch) -> err=1 after CHECK, all 16 bytes still readable; next good packet clears err.
REQ-037 SHALL pass: NPORT=3, header addr=3, 5 payload bytes -> drop pulses 1 cycle, no vld_out rises, next valid packet accepted immediately.
REQ-038 SHALL pass: rst=1 after 4th payload byte -> all outputs at reset values next cycle; following addr-0 packet delivered intact with err=0.
